// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared ALU control constants (ALU codes, ALU-op classes, funct values)
package ula_pkg;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_NOR = 3'b100;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ORI    = 2'b11;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_AND = 4'b0100;
    localparam logic [3:0] FN_OR  = 4'b0101;
    localparam logic [3:0] FN_NOR = 4'b0111;
    localparam logic [3:0] FN_JR  = 4'b1000;
    localparam logic [3:0] FN_SLT = 4'b1010;

endpackage

// File: rtl/controle_ula_dec.sv
// rtl/controle_ula_dec.sv - combinational ALU control decode; nor support under ULA_NOR_EN
module controle_ula_dec
    import ula_pkg::*;
(
    input  logic [1:0] ula_opcode_i,
    input  logic [3:0] funcao_i,
    output logic [2:0] ula_control_o,
    output logic       controle_jr_o
);

    always_comb begin
        ula_control_o = ULA_ADD;
        controle_jr_o = 1'b0;
        case (ula_opcode_i)
            ALUOP_MEM:    ula_control_o = ULA_ADD;
            ALUOP_BRANCH: ula_control_o = ULA_SUB;
            ALUOP_ORI:    ula_control_o = ULA_OR;
            default: begin
                // R-type: unknown funct codes fall back to add so no X ever escapes
                case (funcao_i)
                    FN_ADD: ula_control_o = ULA_ADD;
                    FN_SUB: ula_control_o = ULA_SUB;
                    FN_AND: ula_control_o = ULA_AND;
                    FN_OR:  ula_control_o = ULA_OR;
                    FN_SLT: ula_control_o = ULA_SLT;
                    FN_JR: begin
                        ula_control_o = ULA_ADD;
                        controle_jr_o = 1'b1;
                    end
`ifdef ULA_NOR_EN
                    FN_NOR: ula_control_o = ULA_NOR;
`endif
                    default: ula_control_o = ULA_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/controle_ula.sv
// rtl/controle_ula.sv - registered ALU control decoder top; ULA_NOR_EN enables nor decode
module controle_ula
    import ula_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] ula_opcode,
    input  logic [3:0] funcao,
    output logic       controle_jr,
    output logic [2:0] ula_control
);

    logic [2:0] ula_control_d;
    logic [2:0] ula_control_q;
    logic       controle_jr_d;
    logic       controle_jr_q;

    controle_ula_dec u_dec (
        .ula_opcode_i  (ula_opcode),
        .funcao_i      (funcao),
        .ula_control_o (ula_control_d),
        .controle_jr_o (controle_jr_d)
    );

    // Reset value is add so the ALU does something harmless while held in reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ula_control_q <= ULA_ADD;
            controle_jr_q <= 1'b0;
        end else begin
            ula_control_q <= ula_control_d;
            controle_jr_q <= controle_jr_d;
        end
    end

    assign ula_control = ula_control_q;
    assign controle_jr = controle_jr_q;

endmodule

// File: tb/tb_controle_ula.sv
// tb/tb_controle_ula.sv - directed self-checking bench for controle_ula (honours ULA_NOR_EN)
module tb_controle_ula;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] ula_opcode = 2'b00;
    logic [3:0] funcao = 4'b0000;
    logic       controle_jr;
    logic [2:0] ula_control;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    controle_ula dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ula_opcode  (ula_opcode),
        .funcao      (funcao),
        .controle_jr (controle_jr),
        .ula_control (ula_control)
    );

    // Hand-written R-type table, indexed by funcao
    logic [2:0] rtab [16];
    initial begin
        rtab[0]  = 3'b010; rtab[1]  = 3'b010; rtab[2]  = 3'b110; rtab[3]  = 3'b010;
        rtab[4]  = 3'b000; rtab[5]  = 3'b001; rtab[6]  = 3'b010;
`ifdef ULA_NOR_EN
        rtab[7]  = 3'b100;
`else
        rtab[7]  = 3'b010;
`endif
        rtab[8]  = 3'b010; rtab[9]  = 3'b010; rtab[10] = 3'b111; rtab[11] = 3'b010;
        rtab[12] = 3'b010; rtab[13] = 3'b010; rtab[14] = 3'b010; rtab[15] = 3'b010;
    end

    task automatic test_reset();
        ula_opcode = 2'b10;
        funcao     = 4'b1000;
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if (ula_control !== 3'b010 || controle_jr !== 1'b0)
            $display("FAIL reset_async: got ctl=%b jr=%b want ctl=010 jr=0", ula_control, controle_jr);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_total++;
        if (ula_control !== 3'b010 || controle_jr !== 1'b0)
            $display("FAIL reset_hold: got ctl=%b jr=%b want ctl=010 jr=0", ula_control, controle_jr);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (ula_control !== 3'b010 || controle_jr !== 1'b1)
            $display("FAIL reset_release_jr: got ctl=%b jr=%b want ctl=010 jr=1", ula_control, controle_jr);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [2:0] exp_ctl;
        logic       exp_jr;
        for (int op = 0; op < 4; op++) begin
            for (int fn = 0; fn < 16; fn++) begin
                ula_opcode = op[1:0];
                funcao     = fn[3:0];
                case (op)
                    0: exp_ctl = 3'b010;
                    1: exp_ctl = 3'b110;
                    2: exp_ctl = rtab[fn];
                    default: exp_ctl = 3'b001;
                endcase
                exp_jr = (op == 2 && fn == 8);
                @(negedge clock);
                n_total++;
                if (ula_control !== exp_ctl || controle_jr !== exp_jr)
                    $display("FAIL sweep op=%0d fn=%0d: got ctl=%b jr=%b want ctl=%b jr=%b",
                             op, fn, ula_control, controle_jr, exp_ctl, exp_jr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_jr_exclusive();
        logic [1:0] ops [4];
        ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b11; ops[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            ula_opcode = ops[i];
            funcao     = 4'b1000;
            @(negedge clock);
            n_total++;
            if (controle_jr !== (i == 3))
                $display("FAIL jr_excl op=%b: got jr=%b want jr=%b", ops[i], controle_jr, (i == 3));
            else n_pass++;
        end
        n_total++;
        if (ula_control !== 3'b010)
            $display("FAIL jr_ctl: got ctl=%b want ctl=010", ula_control);
        else n_pass++;
    endtask

    task automatic test_latency();
        ula_opcode = 2'b01;
        funcao     = 4'b0100;
        @(negedge clock);
        ula_opcode = 2'b10;
        funcao     = 4'b0100;
        #2;
        n_total++;
        if (ula_control !== 3'b110)
            $display("FAIL latency_hold: got ctl=%b want ctl=110", ula_control);
        else n_pass++;
        @(posedge clock);
        #1;
        n_total++;
        if (ula_control !== 3'b000 || controle_jr !== 1'b0)
            $display("FAIL latency_update: got ctl=%b jr=%b want ctl=000 jr=0", ula_control, controle_jr);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        @(negedge clock);
        ula_opcode = 2'b10;
        funcao     = 4'b0010;
        @(negedge clock);
        n_total++;
        if (ula_control !== 3'b110)
            $display("FAIL midreset_pre: got ctl=%b want ctl=110", ula_control);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if (ula_control !== 3'b010 || controle_jr !== 1'b0)
            $display("FAIL midreset_async: got ctl=%b jr=%b want ctl=010 jr=0", ula_control, controle_jr);
        else n_pass++;
        ula_opcode = 2'b11;
        funcao     = 4'b1000;
        @(posedge clock);
        #1;
        n_total++;
        if (ula_control !== 3'b010)
            $display("FAIL midreset_held: got ctl=%b want ctl=010", ula_control);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_total++;
        if (ula_control !== 3'b001 || controle_jr !== 1'b0)
            $display("FAIL midreset_resample: got ctl=%b jr=%b want ctl=001 jr=0", ula_control, controle_jr);
        else n_pass++;
    endtask

    task automatic test_nor();
        logic [2:0] exp_ctl;
`ifdef ULA_NOR_EN
        exp_ctl = 3'b100;
`else
        exp_ctl = 3'b010;
`endif
        @(negedge clock);
        ula_opcode = 2'b10;
        funcao     = 4'b0111;
        @(negedge clock);
        n_total++;
        if (ula_control !== exp_ctl || controle_jr !== 1'b0)
            $display("FAIL nor: got ctl=%b jr=%b want ctl=%b jr=0", ula_control, controle_jr, exp_ctl);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_jr_exclusive();
        test_latency();
        test_mid_reset();
        test_nor();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
